// File: rtl/dispatch_router.sv
// dispatch_router: in-order FIFO between decode and the ALU / LSU / branch
// issue queues. The head is steered by opcode class; illegal heads are
// dropped in one cycle, and cycles a legal head waits on its queue are counted.
module dispatch_router #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_aluop,
  input  logic [6:0]       in_opcode,
  output logic [31:0]      out_instr,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_aluop,
  output logic [6:0]       out_opcode,
  output logic             alu_valid,
  output logic             lsu_valid,
  output logic             br_valid,
  input  logic             alu_ready,
  input  logic             lsu_ready,
  input  logic             br_ready,
  output logic             illegal_pulse,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  aluop;
    logic [6:0]  opcode;
  } entry_t;

  entry_t      mem [DEPTH];
  entry_t      entry_in;
  entry_t      head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty, full, push, pop, hs, stall;
  logic        is_alu, is_lsu, is_br, is_ill;

  // Extra MSB on each pointer tells full from empty when the low bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Depends only on full/flush so the issue-queue readies never reach decode.
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign entry_in = {in_instr, in_rs1, in_rs2, in_rd, in_aluop, in_opcode};

  // Head is read straight from storage; zeroed when nothing is buffered.
  assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign out_instr  = head.instr;
  assign out_rs1    = head.rs1;
  assign out_rs2    = head.rs2;
  assign out_rd     = head.rd;
  assign out_aluop  = head.aluop;
  assign out_opcode = head.opcode;

  // Opcode class of the head entry.
  always_comb begin
    is_alu = 1'b0;
    is_lsu = 1'b0;
    is_br  = 1'b0;
    case (head.opcode)
      7'b0110011, 7'b0010011, 7'b0110111: is_alu = 1'b1;
      7'b0000011, 7'b0100011:             is_lsu = 1'b1;
      7'b1100011, 7'b1100111:             is_br  = 1'b1;
      default: ;
    endcase
  end

  assign is_ill        = !empty && !(is_alu || is_lsu || is_br);
  assign alu_valid     = !empty && !flush && is_alu;
  assign lsu_valid     = !empty && !flush && is_lsu;
  assign br_valid      = !empty && !flush && is_br;
  assign illegal_pulse = !flush && is_ill;

  assign hs    = (alu_valid && alu_ready) || (lsu_valid && lsu_ready) || (br_valid && br_ready);
  assign stall = (alu_valid && !alu_ready) || (lsu_valid && !lsu_ready) || (br_valid && !br_ready);
  assign pop   = hs || illegal_pulse;

  // Pointer update: reset beats flush; push and pop may happen together.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Payload storage, no reset needed: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr[AW-1:0]] <= entry_in;
  end

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                        stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_dispatch_router.sv
// Bench for dispatch_router: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dispatch_router;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  aluop;
    logic [6:0]  opcode;
  } entry_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, alu_ready, lsu_ready, br_ready;
  entry_t inp;
  logic in_ready, alu_valid, lsu_valid, br_valid, illegal_pulse;
  logic [31:0] out_instr;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_aluop;
  logic [6:0]  out_opcode;
  logic [CNT_W-1:0] stall_cnt;

  dispatch_router #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(inp.instr), .in_rs1(inp.rs1), .in_rs2(inp.rs2), .in_rd(inp.rd),
    .in_aluop(inp.aluop), .in_opcode(inp.opcode),
    .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_aluop(out_aluop), .out_opcode(out_opcode),
    .alu_valid(alu_valid), .lsu_valid(lsu_valid), .br_valid(br_valid),
    .alu_ready(alu_ready), .lsu_ready(lsu_ready), .br_ready(br_ready),
    .illegal_pulse(illegal_pulse), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  entry_t q[$];
  int     mdl_stall = 0;
  bit     mdl_ok = 0;
  int     n_pass = 0;
  int     n_tot = 0;

  // 0 = ALU, 1 = LSU, 2 = branch, 3 = illegal
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111: return 0;
      7'b0000011, 7'b0100011:             return 1;
      7'b1100011, 7'b1100111:             return 2;
      default:                            return 3;
    endcase
  endfunction

  function automatic bit rdy_of(input int c);
    return (c == 0) ? alu_ready : (c == 1) ? lsu_ready : br_ready;
  endfunction

  function automatic entry_t mkw(input logic [31:0] w, input logic [4:0] rd);
    entry_t e;
    e.instr = w; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = rd;
    e.aluop = w[14:12]; e.opcode = w[6:0];
    return e;
  endfunction

  function automatic logic [31:0] addi_w(input int imm);
    logic [11:0] i12;
    i12 = imm[11:0];
    return {i12, 5'd1, 3'b000, 5'd1, 7'b0010011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Compare every DUT output against the model, mid-cycle.
  task automatic settle();
    entry_t h;
    bit     pres;
    int     c;
    @(negedge clk);
    if (mdl_ok) begin
      pres = (q.size() > 0);
      h = pres ? q[0] : '0;
      c = cls_of(h.opcode);
      chk("in_ready",      32'(in_ready),      32'((q.size() < DEPTH) && !flush));
      chk("alu_valid",     32'(alu_valid),     32'(pres && !flush && c == 0));
      chk("lsu_valid",     32'(lsu_valid),     32'(pres && !flush && c == 1));
      chk("br_valid",      32'(br_valid),      32'(pres && !flush && c == 2));
      chk("illegal_pulse", 32'(illegal_pulse), 32'(pres && !flush && c == 3));
      chk("out_instr",     out_instr,          h.instr);
      chk("out_rs1",       32'(out_rs1),       32'(h.rs1));
      chk("out_rs2",       32'(out_rs2),       32'(h.rs2));
      chk("out_rd",        32'(out_rd),        32'(h.rd));
      chk("out_aluop",     32'(out_aluop),     32'(h.aluop));
      chk("out_opcode",    32'(out_opcode),    32'(h.opcode));
      chk("stall_cnt",     32'(stall_cnt),     32'(mdl_stall));
    end
  endtask

  // Advance the model at the clock edge, then move off the edge.
  task automatic tick();
    bit can_push, do_pop;
    int c;
    @(posedge clk);
    if (reset) begin
      q.delete();
      mdl_stall = 0;
      mdl_ok = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      can_push = in_valid && (q.size() < DEPTH);
      do_pop = 0;
      if (q.size() > 0) begin
        c = cls_of(q[0].opcode);
        if (c == 3 || rdy_of(c)) do_pop = 1;
        else if (mdl_stall < CNT_MAX) mdl_stall++;
      end
      if (do_pop) void'(q.pop_front());
      if (can_push) q.push_back(inp);
    end
    #1;
  endtask

  entry_t ADD, LW, BNE, ILL;
  logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011,
                          7'b0100011, 7'b1100011, 7'b1100111, 7'b1111111, 7'b0000000};

  initial begin
    ADD = mkw(32'h002081B3, 5'd3);
    LW  = mkw(32'h0000A103, 5'd2);
    BNE = mkw(32'h00209463, 5'd0);
    ILL = mkw(32'h0000007F, 5'd4);
    reset = 1; flush = 0; in_valid = 0; inp = '0;
    alu_ready = 1; lsu_ready = 1; br_ready = 1;
    tick(); tick();
    reset = 0;
    settle();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_valids", 32'(alu_valid | lsu_valid | br_valid | illegal_pulse), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    tick();

    // ADD, LW, BNE back to back, all queues ready
    inp = ADD; in_valid = 1; settle(); chk("t1_lat", 32'(alu_valid), 32'd0); tick();
    inp = LW;  settle(); chk("t1_alu", 32'(alu_valid), 32'd1); chk("t1_rd3", 32'(out_rd), 32'd3); tick();
    inp = BNE; settle(); chk("t1_lsu", 32'(lsu_valid), 32'd1); chk("t1_rd2", 32'(out_rd), 32'd2); tick();
    in_valid = 0; settle(); chk("t1_br", 32'(br_valid), 32'd1); chk("t1_rd0", 32'(out_rd), 32'd0); tick();
    settle(); chk("t1_empty", 32'(out_instr), 32'd0); tick();

    // fill with 4 ADDI while ALU is stalled
    alu_ready = 0;
    for (int i = 0; i < 4; i++) begin
      inp = mkw(addi_w(i), 5'd1); in_valid = 1; settle(); tick();
    end
    in_valid = 0;
    settle(); chk("t2_full", 32'(in_ready), 32'd0); chk("t2_stall3", 32'(stall_cnt), 32'd3); tick();
    settle(); tick();
    alu_ready = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (i == 0) chk("t2_stall5", 32'(stall_cnt), 32'd5);
      chk("t2_drain_v", 32'(alu_valid), 32'd1);
      chk("t2_drain_i", out_instr, addi_w(i));
      tick();
    end

    // in-order blocking behind a stalled LW
    lsu_ready = 0;
    inp = LW; in_valid = 1; settle(); tick();
    inp = ADD; settle(); tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("t3_block", 32'({alu_valid, lsu_valid}), 32'b01); tick();
    end
    lsu_ready = 1;
    settle(); chk("t3_lsu_hs", 32'(lsu_valid), 32'd1); tick();
    settle(); chk("t3_alu", 32'(alu_valid), 32'd1); chk("t3_rd", 32'(out_rd), 32'd3); tick();

    // illegal opcode dropped, then ADD
    inp = ILL; in_valid = 1; settle(); tick();
    inp = ADD; settle();
    chk("t4_ill", 32'(illegal_pulse), 32'd1);
    chk("t4_novalid", 32'(alu_valid | lsu_valid | br_valid), 32'd0);
    tick();
    in_valid = 0; settle();
    chk("t4_ill_off", 32'(illegal_pulse), 32'd0); chk("t4_add", 32'(alu_valid), 32'd1);
    tick();

    // flush with 3 buffered entries and a live input
    alu_ready = 0;
    for (int i = 0; i < 3; i++) begin
      inp = mkw(addi_w(40 + i), 5'd1); in_valid = 1; settle(); tick();
    end
    flush = 1; alu_ready = 1; inp = mkw(addi_w(77), 5'd1);
    settle(); chk("t5_nohs", 32'(alu_valid), 32'd0); chk("t5_nordy", 32'(in_ready), 32'd0); tick();
    flush = 0; in_valid = 0;
    settle(); chk("t5_rdy", 32'(in_ready), 32'd1); chk("t5_empty", 32'(alu_valid), 32'd0); tick();

    // 10 enqueue/dequeue pairs across the pointer wrap, then reset mid-stream
    for (int i = 0; i < 10; i++) begin
      inp = mkw(addi_w(100 + i), 5'd1); in_valid = 1; settle();
      if (i > 0) chk("t6_order", out_instr, addi_w(99 + i));
      tick();
    end
    reset = 1; settle(); tick();
    reset = 0; in_valid = 0;
    settle();
    chk("t6_rst_v", 32'(alu_valid | lsu_valid | br_valid), 32'd0);
    chk("t6_rst_cnt", 32'(stall_cnt), 32'd0);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 499) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      inp.instr  = $urandom;
      inp.rs1    = 5'($urandom); inp.rs2 = 5'($urandom); inp.rd = 5'($urandom);
      inp.aluop  = 3'($urandom);
      inp.opcode = ops[$urandom_range(0, 8)];
      alu_ready = ($urandom_range(0, 3) != 0);
      lsu_ready = ($urandom_range(0, 2) != 0);
      br_ready  = ($urandom_range(0, 1) != 0);
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
